// File: rtl/remote_player_pkt_decoder.sv
// Parses UART RX bytes into remote player x/y/level, buffers accepted packets and commits them on frame_tick.
// Optional CHK byte support is enabled by defining REMOTE_PKT_CHKSUM_EN.
module remote_player_pkt_decoder #(
  parameter logic [7:0] HEADER_BYTE      = 8'hA5,
  parameter int         BYTE_TIMEOUT_CYC = 65000,
  parameter int         LINK_TIMEOUT_FR  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_tick,
  output logic [11:0] x_value,
  output logic [11:0] y_value,
  output logic [1:0]  level_remote,
  output logic        remote_active,
  output logic        pkt_stb,
  output logic [7:0]  pkt_err_cnt,
  output logic [2:0]  dbg_state
);

  // rx_valid is a one-cycle strobe with no back-pressure: every byte seen with rx_valid=1 is consumed that cycle.
  localparam int GAP_W  = $clog2(BYTE_TIMEOUT_CYC + 1);
  localparam int MISS_W = $clog2(LINK_TIMEOUT_FR + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_X_HI = 3'd1,
    S_X_LO = 3'd2,
    S_Y_HI = 3'd3,
    S_Y_LO = 3'd4,
    S_LVL  = 3'd5
`ifdef REMOTE_PKT_CHKSUM_EN
    , S_CHK = 3'd6
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d, gap_inc;
  logic [11:0]         asm_x_q, asm_x_d, asm_y_q, asm_y_d;
  logic [11:0]         shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic [1:0]          shadow_lvl_q, shadow_lvl_d;
  logic                pending_q, pending_d;
  logic [11:0]         x_q, x_d, y_q, y_d;
  logic [1:0]          lvl_q, lvl_d;
  logic                active_q, active_d;
  logic                stb_q, stb_d;
  logic [7:0]          err_q, err_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                byte_timeout, pkt_reject, pkt_accept;
  logic [1:0]          accept_lvl;
`ifdef REMOTE_PKT_CHKSUM_EN
  logic [1:0]          asm_lvl_q, asm_lvl_d;
  logic [7:0]          chk_q, chk_d;
  assign accept_lvl = asm_lvl_q;
`else
  assign accept_lvl = rx_data[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      asm_x_q      <= '0;
      asm_y_q      <= '0;
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      shadow_lvl_q <= '0;
      pending_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      lvl_q        <= '0;
      active_q     <= 1'b0;
      stb_q        <= 1'b0;
      err_q        <= '0;
      miss_q       <= '0;
`ifdef REMOTE_PKT_CHKSUM_EN
      asm_lvl_q    <= '0;
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      asm_x_q      <= asm_x_d;
      asm_y_q      <= asm_y_d;
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      shadow_lvl_q <= shadow_lvl_d;
      pending_q    <= pending_d;
      x_q          <= x_d;
      y_q          <= y_d;
      lvl_q        <= lvl_d;
      active_q     <= active_d;
      stb_q        <= stb_d;
      err_q        <= err_d;
      miss_q       <= miss_d;
`ifdef REMOTE_PKT_CHKSUM_EN
      asm_lvl_q    <= asm_lvl_d;
      chk_q        <= chk_d;
`endif
    end
  end

  // Inter-byte gap: abort fires on the cycle the count reaches the limit, unless a byte arrives then.
  always_comb begin
    gap_inc      = gap_q + GAP_W'(1);
    gap_d        = '0;
    byte_timeout = 1'b0;
    if (state_q != S_IDLE && !rx_valid) begin
      if (gap_inc == GAP_W'(BYTE_TIMEOUT_CYC)) byte_timeout = 1'b1;
      else                                      gap_d        = gap_inc;
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_reject = 1'b0;
    pkt_accept = 1'b0;
    if (byte_timeout) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: if (rx_data == HEADER_BYTE) state_d = S_X_HI;
        S_X_HI: begin
          if (rx_data[7:4] != 4'h0) begin pkt_reject = 1'b1; state_d = S_IDLE; end
          else state_d = S_X_LO;
        end
        S_X_LO: state_d = S_Y_HI;
        S_Y_HI: begin
          if (rx_data[7:4] != 4'h0) begin pkt_reject = 1'b1; state_d = S_IDLE; end
          else state_d = S_Y_LO;
        end
        S_Y_LO: state_d = S_LVL;
        S_LVL: begin
          if (rx_data[7:2] != 6'h0) begin
            pkt_reject = 1'b1;
            state_d    = S_IDLE;
          end else begin
`ifdef REMOTE_PKT_CHKSUM_EN
            state_d = S_CHK;
`else
            pkt_accept = 1'b1;
            state_d    = S_IDLE;
`endif
          end
        end
`ifdef REMOTE_PKT_CHKSUM_EN
        S_CHK: begin
          if (rx_data != chk_q) pkt_reject = 1'b1;
          else                  pkt_accept = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    asm_x_d      = asm_x_q;
    asm_y_d      = asm_y_q;
    shadow_x_d   = shadow_x_q;
    shadow_y_d   = shadow_y_q;
    shadow_lvl_d = shadow_lvl_q;
    pending_d    = pending_q;
    x_d          = x_q;
    y_d          = y_q;
    lvl_d        = lvl_q;
    active_d     = active_q;
    stb_d        = 1'b0;
    err_d        = err_q;
    miss_d       = miss_q;
`ifdef REMOTE_PKT_CHKSUM_EN
    asm_lvl_d    = asm_lvl_q;
    chk_d        = chk_q;
`endif
    if (rx_valid) begin
      case (state_q)
        S_X_HI: asm_x_d[11:8] = rx_data[3:0];
        S_X_LO: asm_x_d[7:0]  = rx_data;
        S_Y_HI: asm_y_d[11:8] = rx_data[3:0];
        S_Y_LO: asm_y_d[7:0]  = rx_data;
        default: ;
      endcase
`ifdef REMOTE_PKT_CHKSUM_EN
      if (state_q == S_X_HI) chk_d = rx_data;
      else                   chk_d = chk_q ^ rx_data;
      if (state_q == S_LVL)  asm_lvl_d = rx_data[1:0];
`endif
    end
    if ((pkt_reject || byte_timeout) && err_q != 8'hFF) err_d = err_q + 8'd1;
    // The tick commits the pre-accept shadow; a same-cycle accept stays pending for the next tick.
    if (frame_tick) begin
      if (pending_q) begin
        x_d       = shadow_x_q;
        y_d       = shadow_y_q;
        lvl_d     = shadow_lvl_q;
        stb_d     = 1'b1;
        active_d  = 1'b1;
        miss_d    = '0;
        pending_d = 1'b0;
      end else begin
        if (miss_q != MISS_W'(LINK_TIMEOUT_FR)) miss_d = miss_q + MISS_W'(1);
        if (miss_d == MISS_W'(LINK_TIMEOUT_FR)) active_d = 1'b0;
      end
    end
    if (pkt_accept) begin
      shadow_x_d   = asm_x_q;
      shadow_y_d   = asm_y_q;
      shadow_lvl_d = accept_lvl;
      pending_d    = 1'b1;
    end
  end

  assign x_value       = x_q;
  assign y_value       = y_q;
  assign level_remote  = lvl_q;
  assign remote_active = active_q;
  assign pkt_stb       = stb_q;
  assign pkt_err_cnt   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_remote_player_pkt_decoder.sv
// Randomized bench for remote_player_pkt_decoder against a packet-level reference model.
module tb_remote_player_pkt_decoder;

  localparam int TO   = 300;
  localparam int LINK = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_tick;
  logic [11:0] x_value, y_value;
  logic [1:0]  level_remote;
  logic        remote_active, pkt_stb;
  logic [7:0]  pkt_err_cnt;
  logic [2:0]  dbg_state;

  remote_player_pkt_decoder #(
    .HEADER_BYTE(8'hA5), .BYTE_TIMEOUT_CYC(TO), .LINK_TIMEOUT_FR(LINK)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .frame_tick(frame_tick),
    .x_value(x_value), .y_value(y_value), .level_remote(level_remote),
    .remote_active(remote_active), .pkt_stb(pkt_stb), .pkt_err_cnt(pkt_err_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [11:0] m_x, m_y, s_x, s_y;
  logic [1:0]  m_l, s_l;
  logic        m_act, m_pend;
  logic [7:0]  m_err;
  int          m_miss;
  logic [7:0]  pkt_q[$];
  logic [25:0] exp_q[$];

  task automatic model_reset();
    m_x = '0; m_y = '0; m_l = '0; m_act = 1'b0; m_pend = 1'b0; m_err = '0; m_miss = 0;
    s_x = '0; s_y = '0; s_l = '0;
    exp_q.delete();
  endtask

  task automatic model_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic model_tick();
    if (m_pend) begin
      m_x = s_x; m_y = s_y; m_l = s_l; m_act = 1'b1; m_miss = 0; m_pend = 1'b0;
      exp_q.push_back({s_x, s_y, s_l});
    end else begin
      if (m_miss < LINK) m_miss++;
      if (m_miss == LINK) m_act = 1'b0;
    end
  endtask

  // Scans pkt_q by the packet rules: how many bytes the decoder consumes and whether it accepts.
  task automatic model_eval(output int used, output bit ok);
    used = pkt_q.size();
    ok   = 1'b1;
    if (pkt_q[1][7:4] != 4'h0)      begin used = 2; ok = 1'b0; end
    else if (pkt_q[3][7:4] != 4'h0) begin used = 4; ok = 1'b0; end
    else if (pkt_q[5][7:2] != 6'h0) begin used = 6; ok = 1'b0; end
`ifdef REMOTE_PKT_CHKSUM_EN
    else if (pkt_q[6] != (pkt_q[1] ^ pkt_q[2] ^ pkt_q[3] ^ pkt_q[4] ^ pkt_q[5])) begin
      used = 7; ok = 1'b0;
    end
`endif
  endtask

  task automatic model_accept(input bit ok);
    if (ok) begin
      m_pend = 1'b1;
      s_x = {pkt_q[1][3:0], pkt_q[2]};
      s_y = {pkt_q[3][3:0], pkt_q[4]};
      s_l = pkt_q[5][1:0];
    end else begin
      model_err();
    end
  endtask

  // fault: 0 none, 1 X_HI high nibble, 2 Y_HI high nibble, 3 LVL high bits, 4 bad CHK
  task automatic make_pkt(input logic [11:0] x, input logic [11:0] y, input logic [1:0] l, input int fault);
    logic [7:0] xh, yh, lv;
    xh = {4'h0, x[11:8]};
    yh = {4'h0, y[11:8]};
    lv = {6'h0, l};
    if (fault == 1) xh[7:4] = 4'($urandom_range(1, 15));
    if (fault == 2) yh[7:4] = 4'($urandom_range(1, 15));
    if (fault == 3) lv[7:2] = 6'($urandom_range(1, 63));
    pkt_q = {8'hA5, xh, x[7:0], yh, y[7:0], lv};
`ifdef REMOTE_PKT_CHKSUM_EN
    pkt_q.push_back((xh ^ x[7:0] ^ yh ^ y[7:0] ^ lv) ^ ((fault == 4) ? 8'($urandom_range(1, 255)) : 8'h00));
`endif
  endtask

  // ---------------- scoreboard: every pkt_stb must match the oldest expected commit ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && pkt_stb === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL stb_unexpected: got pkt_stb=1 with x=%h y=%h l=%0d, required no strobe", x_value, y_value, level_remote);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({x_value, y_value, level_remote} !== e) begin
          n_bad++;
          $display("FAIL commit_value: got x=%h y=%h l=%0d, required x=%h y=%h l=%0d",
                   x_value, y_value, level_remote, e[25:14], e[13:2], e[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_pkt(input int gap_max);
    int used; bit ok;
    model_eval(used, ok);
    for (int i = 0; i < used; i++) begin
      send_byte(pkt_q[i]);
      if (i < used - 1) idle($urandom_range(0, gap_max));
    end
    model_accept(ok);
  endtask

  task automatic tick();
    model_tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({x_value, y_value, level_remote, remote_active, pkt_stb, pkt_err_cnt} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got x=%h y=%h l=%0d act=%b stb=%b err=%0d, required all 0",
               x_value, y_value, level_remote, remote_active, pkt_stb, pkt_err_cnt);
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_basic();
    make_pkt(12'h12C, 12'h0C8, 2'd2, 0);
    send_pkt(0);
    n_cmp++;
    if ({x_value, remote_active} !== 13'h0) begin
      n_bad++; $display("FAIL basic_precommit: got x=%h act=%b required x=0 act=0", x_value, remote_active);
    end
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, remote_active, pkt_stb} !== {12'h12C, 12'h0C8, 2'd2, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL basic_commit: got x=%h y=%h l=%0d act=%b stb=%b required x=12c y=0c8 l=2 act=1 stb=1",
               x_value, y_value, level_remote, remote_active, pkt_stb);
    end
    idle(1);
    n_cmp++;
    if (pkt_stb !== 1'b0) begin n_bad++; $display("FAIL basic_stb_width: got stb=%b required 0", pkt_stb); end
  endtask

  task automatic test_hold_latency();
    make_pkt(12'($urandom), 12'($urandom), 2'($urandom), 0);
    send_pkt(2);
    idle(1000);
    n_cmp++;
    if ({x_value, y_value, level_remote, remote_active} !== {m_x, m_y, m_l, m_act}) begin
      n_bad++; $display("FAIL hold_no_tick: got x=%h y=%h l=%0d required x=%h y=%h l=%0d",
                        x_value, y_value, level_remote, m_x, m_y, m_l);
    end
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, pkt_stb} !== {s_x, s_y, s_l, 1'b1}) begin
      n_bad++; $display("FAIL hold_commit_latency: got x=%h y=%h l=%0d stb=%b required x=%h y=%h l=%0d stb=1",
                        x_value, y_value, level_remote, pkt_stb, s_x, s_y, s_l);
    end
  endtask

  task automatic test_latest_wins();
    make_pkt(12'd100, 12'd7, 2'd1, 0);
    send_pkt(1);
    make_pkt(12'd200, 12'd9, 2'd3, 0);
    send_pkt(1);
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote} !== {12'd200, 12'd9, 2'd3}) begin
      n_bad++; $display("FAIL latest_wins: got x=%0d y=%0d l=%0d required x=200 y=9 l=3", x_value, y_value, level_remote);
    end
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0 || pkt_stb !== 1'b0) begin
      n_bad++; $display("FAIL latest_one_stb: got pending_expected=%0d stb=%b required 0 0", exp_q.size(), pkt_stb);
    end
  endtask

  task automatic test_reject_xhi();
    logic [7:0] err0;
    err0 = pkt_err_cnt;
    make_pkt(12'h345, 12'h067, 2'd0, 0);
    pkt_q[1] = 8'h10;
    send_pkt(0);
    n_cmp++;
    if ({pkt_err_cnt, dbg_state, x_value} !== {err0 + 8'd1, 3'd0, m_x}) begin
      n_bad++; $display("FAIL reject_xhi: got err=%0d state=%0d x=%h required err=%0d state=0 x=%h",
                        pkt_err_cnt, dbg_state, x_value, err0 + 8'd1, m_x);
    end
    make_pkt(12'hABC, 12'h0DE, 2'd1, 0);
    send_pkt(1);
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, pkt_stb} !== {12'hABC, 12'h0DE, 2'd1, 1'b1}) begin
      n_bad++; $display("FAIL reject_recover: got x=%h y=%h l=%0d stb=%b required x=abc y=0de l=1 stb=1",
                        x_value, y_value, level_remote, pkt_stb);
    end
  endtask

  task automatic test_byte_timeout();
    int used; bit ok;
    make_pkt(12'h111, 12'h222, 2'd2, 0);
    send_byte(pkt_q[0]); send_byte(pkt_q[1]); send_byte(pkt_q[2]);
    idle(TO + 1);
    model_err();
    n_cmp++;
    if ({pkt_err_cnt, dbg_state} !== {m_err, 3'd0}) begin
      n_bad++; $display("FAIL timeout_abort: got err=%0d state=%0d required err=%0d state=0", pkt_err_cnt, dbg_state, m_err);
    end
    send_pkt(1);
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, pkt_err_cnt} !== {12'h111, 12'h222, 2'd2, m_err}) begin
      n_bad++; $display("FAIL timeout_recover: got x=%h y=%h l=%0d err=%0d required x=111 y=222 l=2 err=%0d",
                        x_value, y_value, level_remote, pkt_err_cnt, m_err);
    end
    // A gap of exactly the limit between two bytes is still legal.
    make_pkt(12'h0F0, 12'h00F, 2'd3, 0);
    model_eval(used, ok);
    send_byte(pkt_q[0]);
    idle(TO - 1);
    for (int i = 1; i < used; i++) send_byte(pkt_q[i]);
    model_accept(ok);
    tick();
    n_cmp++;
    if ({x_value, y_value, pkt_err_cnt} !== {12'h0F0, 12'h00F, m_err}) begin
      n_bad++; $display("FAIL timeout_boundary: got x=%h y=%h err=%0d required x=0f0 y=00f err=%0d",
                        x_value, y_value, pkt_err_cnt, m_err);
    end
  endtask

  task automatic test_simultaneous();
    int used; bit ok;
    make_pkt(12'h321, 12'h654, 2'd1, 0);
    send_pkt(1);
    make_pkt(12'h789, 12'h0AB, 2'd2, 0);
    model_eval(used, ok);
    for (int i = 0; i < used - 1; i++) send_byte(pkt_q[i]);
    model_tick();
    model_accept(ok);
    rx_data = pkt_q[used - 1]; rx_valid = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; frame_tick = 1'b0;
    n_cmp++;
    if ({x_value, y_value, level_remote} !== {12'h321, 12'h654, 2'd1}) begin
      n_bad++; $display("FAIL simul_old_commit: got x=%h y=%h l=%0d required x=321 y=654 l=1", x_value, y_value, level_remote);
    end
    idle(2);
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, pkt_stb} !== {12'h789, 12'h0AB, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL simul_new_pending: got x=%h y=%h l=%0d stb=%b required x=789 y=0ab l=2 stb=1",
                        x_value, y_value, level_remote, pkt_stb);
    end
  endtask

  task automatic test_link_timeout();
    make_pkt(12'h5A5, 12'h1E1, 2'd3, 0);
    send_pkt(1);
    tick();
    for (int i = 1; i <= LINK; i++) begin
      tick();
      idle($urandom_range(0, 3));
      if (i == LINK - 1) begin
        n_cmp++;
        if (remote_active !== 1'b1) begin n_bad++; $display("FAIL link_before_limit: got act=%b required 1", remote_active); end
      end
    end
    n_cmp++;
    if ({remote_active, x_value, y_value, level_remote} !== {1'b0, 12'h5A5, 12'h1E1, 2'd3} || m_act !== 1'b0) begin
      n_bad++; $display("FAIL link_timeout: got act=%b x=%h y=%h l=%0d required act=0 x=5a5 y=1e1 l=3",
                        remote_active, x_value, y_value, level_remote);
    end
  endtask

`ifdef REMOTE_PKT_CHKSUM_EN
  task automatic test_bad_chk();
    make_pkt(12'h222, 12'h333, 2'd1, 4);
    send_pkt(1);
    tick();
    n_cmp++;
    if ({pkt_err_cnt, x_value, pkt_stb} !== {m_err, m_x, 1'b0}) begin
      n_bad++; $display("FAIL bad_chk: got err=%0d x=%h stb=%b required err=%0d x=%h stb=0",
                        pkt_err_cnt, x_value, pkt_stb, m_err, m_x);
    end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [7:0] j;
      int nf;
      bit had_pend;
      repeat ($urandom_range(0, 2)) begin
        do j = 8'($urandom); while (j == 8'hA5);
        send_byte(j);
        idle($urandom_range(0, 2));
      end
`ifdef REMOTE_PKT_CHKSUM_EN
      nf = 4;
`else
      nf = 3;
`endif
      make_pkt(12'($urandom), 12'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, nf) : 0);
      send_pkt(3);
      if ($urandom_range(0, 1) == 1) begin
        had_pend = m_pend;
        tick();
        n_cmp++;
        if ({x_value, y_value, level_remote, remote_active, pkt_err_cnt, pkt_stb} !== {m_x, m_y, m_l, m_act, m_err, had_pend}) begin
          n_bad++;
          $display("FAIL random_%0d: got x=%h y=%h l=%0d act=%b err=%0d stb=%b required x=%h y=%h l=%0d act=%b err=%0d stb=%b",
                   it, x_value, y_value, level_remote, remote_active, pkt_err_cnt, pkt_stb,
                   m_x, m_y, m_l, m_act, m_err, had_pend);
        end
      end
    end
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, pkt_err_cnt} !== {m_x, m_y, m_l, m_err}) begin
      n_bad++; $display("FAIL random_final: got x=%h y=%h l=%0d err=%0d required x=%h y=%h l=%0d err=%0d",
                        x_value, y_value, level_remote, pkt_err_cnt, m_x, m_y, m_l, m_err);
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 258; i++) begin
      make_pkt(12'($urandom), 12'($urandom), 2'($urandom), 1);
      send_pkt(0);
    end
    n_cmp++;
    if (pkt_err_cnt !== 8'hFF || m_err !== 8'hFF) begin
      n_bad++; $display("FAIL err_saturate: got err=%0d required 255", pkt_err_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    make_pkt(12'h0C3, 12'h03C, 2'd2, 0);
    send_byte(pkt_q[0]); send_byte(pkt_q[1]); send_byte(pkt_q[2]);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({x_value, y_value, level_remote, remote_active, pkt_err_cnt, dbg_state} !== 38'h0) begin
      n_bad++; $display("FAIL reset_mid_packet: got x=%h act=%b err=%0d state=%0d required all 0",
                        x_value, remote_active, pkt_err_cnt, dbg_state);
    end
    send_pkt(2);
    tick();
    n_cmp++;
    if ({x_value, y_value, level_remote, remote_active, pkt_err_cnt} !== {12'h0C3, 12'h03C, 2'd2, 1'b1, 8'd0}) begin
      n_bad++; $display("FAIL reset_recover: got x=%h y=%h l=%0d act=%b err=%0d required x=0c3 y=03c l=2 act=1 err=0",
                        x_value, y_value, level_remote, remote_active, pkt_err_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; frame_tick = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(1);
    test_reset();
    test_basic();
    test_hold_latency();
    test_latest_wins();
    test_reject_xhi();
    test_byte_timeout();
    test_simultaneous();
    test_link_timeout();
`ifdef REMOTE_PKT_CHKSUM_EN
    test_bad_chk();
`endif
    test_random();
    test_err_saturate();
    test_reset_mid_packet();
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL missing_stb: got %0d expected commits never strobed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
